// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned CNT_W          = 6;
    localparam int unsigned DIV_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } div_result_t;

    // Two's-complement negate when en is set.
    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic en);
        return en ? (~v + DATA_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, result {hi=rem, lo=quo}.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero finishes in one cycle with hi=a, lo=all-ones.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
)
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic                annul_i,
    output logic                stall_div_o,
    output logic                ready_o,
    output logic [2*DATA_W-1:0] result_o
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvsr_q;
    logic              sign_a_q, sign_b_q, is_signed_q;

    logic              start_ok;
    logic              last_step;
    logic              zero_fast;
    logic [DATA_W:0]   shifted;
    logic              ge;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] rem_n, quo_n;
    div_result_t       final_res;
    div_result_t       zero_res;

    assign start_ok  = start_i & ~annul_i;
    assign last_step = (cnt_q == CNT_W'(DIV_CYCLES - 1));

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = start_ok & (b_i == '0);
`else
    assign zero_fast = 1'b0;
`endif

    // One restoring shift-subtract step on the latched magnitudes.
    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        ge      = (shifted >= {1'b0, dvsr_q});
        diff    = DATA_W'(shifted - {1'b0, dvsr_q});
        rem_n   = ge ? diff : shifted[DATA_W-1:0];
        quo_n   = {quo_q[DATA_W-2:0], ge};
    end

    // Sign fix-up: quotient negative on sign mismatch, remainder follows the dividend.
    always_comb begin
        final_res.lo = neg_if(quo_n, is_signed_q & (sign_a_q ^ sign_b_q));
        final_res.hi = neg_if(rem_n, is_signed_q & sign_a_q);
        zero_res.hi  = a_i;
        zero_res.lo  = '1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the combinational hazard-unit stall.
    always_comb begin
        state_d     = state_q;
        stall_div_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    stall_div_o = 1'b1;
                    state_d     = zero_fast ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    stall_div_o = 1'b1;
                    if (last_step) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!resetn) begin
            stall_div_o = 1'b0;
        end
    end

    // Operand latch, iteration datapath and registered result/ready.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            is_signed_q <= 1'b0;
            ready_o     <= 1'b0;
            result_o    <= '0;
        end else begin
            ready_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        cnt_q       <= '0;
                        rem_q       <= '0;
                        quo_q       <= neg_if(a_i, signed_i & a_i[DATA_W-1]);
                        dvsr_q      <= neg_if(b_i, signed_i & b_i[DATA_W-1]);
                        sign_a_q    <= a_i[DATA_W-1];
                        sign_b_q    <= b_i[DATA_W-1];
                        is_signed_q <= signed_i;
                        if (zero_fast) begin
                            result_o <= zero_res;
                            ready_o  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!annul_i) begin
                        rem_q <= rem_n;
                        quo_q <= quo_n;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_step) begin
                            result_o <= final_res;
                            ready_o  <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic reference model plus per-cycle stall/ready/result compare.
module tb_div_unit;

    localparam int DC = 32;

    logic        clk;
    logic        resetn;
    logic        start_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        annul_i;
    logic        stall_div_o;
    logic        ready_o;
    logic [63:0] result_o;

    div_unit #(.DIV_CYCLES(DC)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .annul_i     (annul_i),
        .stall_div_o (stall_div_o),
        .ready_o     (ready_o),
        .result_o    (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expectation schedule written by the driver, consumed by the compare process.
    int          t_acc   = -1;
    int          t_rdy   = -1;
    int          t_end   = -1;
    int          rst_clr = -1;
    logic [63:0] pend    = '0;
    logic [63:0] held    = '0;
    bit          chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Reference: divide magnitudes with plain arithmetic, then apply signs.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb, q, r;
        bit na, nb;
        na = s && a[31];
        nb = s && b[31];
        ma = na ? (32'd0 - a) : a;
        mb = nb ? (32'd0 - b) : b;
        if (mb == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
            return {a, 32'hFFFFFFFF};
`else
            q = 32'hFFFFFFFF;
            r = ma;
`endif
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (na != nb) q = 32'd0 - q;
        if (na) r = 32'd0 - r;
        return {r, q};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == rst_clr) held = '0;
            if (cyc == t_rdy) held = pend;
            check("stall", 64'(stall_div_o),
                  64'(resetn && t_acc >= 0 && cyc >= t_acc && cyc <= t_end));
            check("ready", 64'(ready_o), 64'(cyc == t_rdy));
            check("result", result_o, held);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide; annul_k / rst_k > 0 inject annul or reset k cycles after start.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input int annul_k, input int rst_k);
        int t0;
        int lat;
        step();
        t0       = cyc;
        a_i      = a;
        b_i      = b;
        signed_i = s;
        start_i  = 1'b1;
        lat      = DC + 1;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) lat = 1;
`endif
        pend  = model(a, b, s);
        t_acc = t0;
        t_rdy = t0 + lat;
        t_end = t0 + lat - 1;
        if (annul_k == 0 && rst_k == 0) check("model_vs_vector", pend, exp);
        for (int k = 1; k <= lat; k++) begin
            step();
            if (k == annul_k) begin
                annul_i = 1'b1;
                t_rdy   = -1;
                t_end   = t0 + k - 1;
                step();
                start_i = 1'b0;
                annul_i = 1'b0;
                return;
            end
            if (k == rst_k) begin
                resetn  = 1'b0;
                t_rdy   = -1;
                t_end   = t0 + k - 1;
                rst_clr = t0 + k + 1;
                step();
                resetn  = 1'b1;
                start_i = 1'b0;
                check("reset_result", result_o, 64'd0);
                return;
            end
        end
        check("done_result", result_o, exp);
        step();
        start_i = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        resetn   = 1'b0;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd0;
        b_i      = 32'd0;
        annul_i  = 1'b0;

        vecs[0] = '{32'd100,       32'd7,         1'b0, {32'h00000002, 32'h0000000E}};
        vecs[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}};
        vecs[2] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, {32'h00000000, 32'h80000000}};
        vecs[3] = '{32'd7,         32'hFFFFFFFE,  1'b1, {32'h00000001, 32'hFFFFFFFD}};
        vecs[4] = '{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, {32'hFFFFFFFF, 32'h00000003}};
        vecs[5] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, {32'h00000000, 32'h00000001}};
        vecs[6] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, {32'h80000000, 32'h00000000}};
        vecs[7] = '{32'd1000000,   32'd3,         1'b0, {32'h00000001, 32'h00051615}};
        vecs[8] = '{32'd0,         32'd5,         1'b1, {32'h00000000, 32'h00000000}};
        vecs[9] = '{32'hFFFFFFFF,  32'd10,        1'b0, {32'h00000005, 32'h19999999}};

        step();
        chk_en = 1'b1;
        step();
        step();
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result0", result_o, 64'd0);
        resetn  = 1'b1;
        start_i = 1'b0;
        step();

        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 0, 0);
            step();
        end

`ifdef DIV_ZERO_FAST_EN
        run_div(32'hFFFFFFF9, 32'd0, 1'b1, {32'hFFFFFFF9, 32'hFFFFFFFF}, 0, 0);
        step();
        run_div(32'd5, 32'd0, 1'b0, {32'h00000005, 32'hFFFFFFFF}, 0, 0);
`else
        run_div(32'hFFFFFFF9, 32'd0, 1'b1, {32'hFFFFFFF9, 32'h00000001}, 0, 0);
        step();
        run_div(32'd5, 32'd0, 1'b0, {32'h00000005, 32'hFFFFFFFF}, 0, 0);
`endif
        step();

        run_div(32'd100, 32'd7, 1'b1, 64'd0, 10, 0);
        repeat (DC + 4) step();
        check("annul_keeps_result", result_o, {32'h00000005, 32'hFFFFFFFF});

        run_div(32'd100, 32'd7, 1'b0, 64'd0, 0, 5);
        repeat (4) step();

        run_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 0);
        repeat (4) step();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
